// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master drives operands and consumes results; slave is the arithmetic unit.
interface addsub_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, op, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, neg, acc
  );

  modport slave (
    input  in_valid, a, b, op, acc_clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, neg, acc
  );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract unit with running accumulator and valid/ready flow control.
// S1 captures the operand beat; S2 holds the registered result and flags.
module addsub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  addsub_pipe_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int MSB    = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
  } rsp_t;

  logic [STAGES:1]  vld_pipe;
  req_t             s1;
  rsp_t             rsp_d, rsp_q;
  logic [WIDTH-1:0] acc_q;
  logic             s2_adv, s1_adv, in_ready;

  // S2 frees up whenever it is empty or its beat is being taken this edge
  assign s2_adv   = !vld_pipe[2] || bus.out_ready;
  assign s1_adv   = vld_pipe[1] && s2_adv;
  assign in_ready = !vld_pipe[1] || s2_adv;

  logic [WIDTH-1:0] x, y;
  logic [WIDTH:0]   sum_w, dif_w;

  // Accumulate ops read acc_q here; acc_q is already updated by any earlier
  // accumulate op because that op moved into S2 on the edge this one entered S1.
  always_comb begin
    x     = s1.op[1] ? acc_q : s1.a;
    y     = s1.op[1] ? s1.a  : s1.b;
    sum_w = {1'b0, x} + {1'b0, y};
    dif_w = {1'b0, x} - {1'b0, y};
    rsp_d = '0;
    if (s1.op[0]) begin
      rsp_d.result = dif_w[MSB:0];
      rsp_d.carry  = dif_w[WIDTH];
      rsp_d.ovf    = (x[MSB] != y[MSB]) && (dif_w[MSB] != x[MSB]);
    end else begin
      rsp_d.result = sum_w[MSB:0];
      rsp_d.carry  = sum_w[WIDTH];
      rsp_d.ovf    = (x[MSB] == y[MSB]) && (sum_w[MSB] != x[MSB]);
    end
    rsp_d.zero = (rsp_d.result == '0);
    rsp_d.neg  = rsp_d.result[MSB];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      rsp_q    <= '0;
      acc_q    <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1 <= '{a: bus.a, b: bus.b, op: bus.op};
      end
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv) rsp_q <= rsp_d;
      // Clear takes priority over a same-edge accumulate write-back
      if (bus.acc_clr)                acc_q <= '0;
      else if (s1_adv && s1.op[1])    acc_q <= rsp_d.result;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_pipe[2];
  assign bus.result    = rsp_q.result;
  assign bus.carry     = rsp_q.carry;
  assign bus.ovf       = rsp_q.ovf;
  assign bus.zero      = rsp_q.zero;
  assign bus.neg       = rsp_q.neg;
  assign bus.acc       = acc_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=4): arithmetic flags, accumulator,
// backpressure stall and mid-flight reset.
module tb_addsub_pipe;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  addsub_pipe_if #(.WIDTH(4)) bus ();

  addsub_pipe #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic clr);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.acc_clr  = clr;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    vecs++; if ({bus.result, bus.carry, bus.ovf, bus.zero, bus.neg} !== 8'h00) begin
      errs++; $display("FAIL reset_flags got=%h exp=00", {bus.result, bus.carry, bus.ovf, bus.zero, bus.neg}); end
    vecs++; if (bus.acc !== 4'h0) begin errs++; $display("FAIL reset_acc got=%h exp=0", bus.acc); end
  endtask

  task automatic test_sub;
    drive(1'b1, 4'h3, 4'h5, 2'b01, 1'b0);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL sub_latency_early got=%b exp=0", bus.out_valid); end
    cyc;
    vecs++; if ({bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg} !== {1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errs++; $display("FAIL sub_3_5 got v/r/c/o/z/n=%b/%h/%b/%b/%b/%b exp=1/e/1/0/0/1",
        bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg); end
    cyc;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL sub_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_add_wrap;
    drive(1'b1, 4'h7, 4'h1, 2'b00, 1'b0);
    cyc;
    drive(1'b1, 4'hF, 4'h1, 2'b00, 1'b0);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    vecs++; if ({bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg} !== {1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      errs++; $display("FAIL add_7_1 got v/r/c/o/z/n=%b/%h/%b/%b/%b/%b exp=1/8/0/1/0/1",
        bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg); end
    cyc;
    vecs++; if ({bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg} !== {1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL add_f_1 got v/r/c/o/z/n=%b/%h/%b/%b/%b/%b exp=1/0/1/0/1/0",
        bus.out_valid, bus.result, bus.carry, bus.ovf, bus.zero, bus.neg); end
    vecs++; if (bus.acc !== 4'h0) begin errs++; $display("FAIL add_acc_untouched got=%h exp=0", bus.acc); end
    cyc;
  endtask

  task automatic test_accumulate;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    cyc;
    drive(1'b1, 4'h5, 4'hA, 2'b10, 1'b0);
    cyc;
    drive(1'b1, 4'h6, 4'hA, 2'b10, 1'b0);
    cyc;
    vecs++; if ({bus.out_valid, bus.result, bus.ovf} !== {1'b1, 4'h5, 1'b0}) begin
      errs++; $display("FAIL acc_beat0 got v/r/o=%b/%h/%b exp=1/5/0", bus.out_valid, bus.result, bus.ovf); end
    drive(1'b1, 4'h2, 4'hA, 2'b11, 1'b0);
    cyc;
    vecs++; if ({bus.out_valid, bus.result, bus.carry, bus.ovf, bus.neg} !== {1'b1, 4'hB, 1'b0, 1'b1, 1'b1}) begin
      errs++; $display("FAIL acc_beat1 got v/r/c/o/n=%b/%h/%b/%b/%b exp=1/b/0/1/1",
        bus.out_valid, bus.result, bus.carry, bus.ovf, bus.neg); end
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    cyc;
    vecs++; if ({bus.out_valid, bus.result, bus.carry, bus.ovf} !== {1'b1, 4'h9, 1'b0, 1'b0}) begin
      errs++; $display("FAIL acc_beat2 got v/r/c/o=%b/%h/%b/%b exp=1/9/0/0",
        bus.out_valid, bus.result, bus.carry, bus.ovf); end
    vecs++; if (bus.acc !== 4'h9) begin errs++; $display("FAIL acc_final got=%h exp=9", bus.acc); end
    cyc;
  endtask

  task automatic test_clr_collide;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    cyc;
    drive(1'b1, 4'h4, 4'h0, 2'b10, 1'b0);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    cyc;
    vecs++; if (bus.acc !== 4'h4) begin errs++; $display("FAIL clr_setup_acc got=%h exp=4", bus.acc); end
    drive(1'b1, 4'h1, 4'h0, 2'b10, 1'b0);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    vecs++; if ({bus.out_valid, bus.result} !== {1'b1, 4'h5}) begin
      errs++; $display("FAIL clr_collide_result got v/r=%b/%h exp=1/5", bus.out_valid, bus.result); end
    vecs++; if (bus.acc !== 4'h0) begin errs++; $display("FAIL clr_collide_acc got=%h exp=0", bus.acc); end
    cyc;
  endtask

  task automatic test_back_to_back_stall;
    int sent, got, stalls, cnt;
    logic saw_full;
    logic [3:0] held;
    logic held_ok;
    sent = 0; got = 0; stalls = 0; saw_full = 1'b0; held_ok = 1'b0; held = 4'h0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      bus.out_ready = !(c >= 2 && c < 5);
      drive(sent < 6, 4'(sent), 4'h1, 2'b00, 1'b0);
      #1;
      if (!bus.in_ready) begin
        saw_full = 1'b1;
        vecs++; if (sent - got !== 2) begin
          errs++; $display("FAIL stall_buffered got=%0d exp=2", sent - got); end
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (held_ok) begin
          vecs++; if (bus.result !== held) begin
            errs++; $display("FAIL stall_hold got=%h exp=%h", bus.result, held); end
        end
        held = bus.result; held_ok = 1'b1; stalls++;
      end else begin
        held_ok = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        vecs++; if (bus.result !== 4'(got + 1)) begin
          errs++; $display("FAIL stream_beat%0d got=%h exp=%h", got, bus.result, 4'(got + 1)); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc;
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    vecs++; if (got !== 6) begin errs++; $display("FAIL stream_count got=%0d exp=6", got); end
    vecs++; if (saw_full !== 1'b1) begin errs++; $display("FAIL stall_in_ready_low got=%b exp=1", saw_full); end
    vecs++; if (stalls !== 3) begin errs++; $display("FAIL stall_cycles got=%0d exp=3", stalls); end
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.out_valid) cnt++;
      cyc;
    end
    vecs++; if (cnt !== 0) begin errs++; $display("FAIL stream_duplicate got=%0d exp=0", cnt); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
    cyc;
    drive(1'b1, 4'h7, 4'h0, 2'b10, 1'b0);
    cyc;
    drive(1'b1, 4'h1, 4'h1, 2'b00, 1'b0);
    cyc;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    #1;
    vecs++; if ({bus.acc, bus.out_valid, bus.in_ready} !== {4'h7, 1'b1, 1'b0}) begin
      errs++; $display("FAIL rstmid_setup got acc/ov/ir=%h/%b/%b exp=7/1/0", bus.acc, bus.out_valid, bus.in_ready); end
    rst_n = 1'b0;
    #1;
    vecs++; if ({bus.out_valid, bus.acc, bus.in_ready} !== {1'b0, 4'h0, 1'b1}) begin
      errs++; $display("FAIL rstmid_flush got ov/acc/ir=%b/%h/%b exp=0/0/1", bus.out_valid, bus.acc, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc;
      vecs++; if (bus.out_valid !== 1'b0) begin
        errs++; $display("FAIL rstmid_stale cycle%0d got=%b exp=0", c, bus.out_valid); end
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_sub;
    test_add_wrap;
    test_accumulate;
    test_clr_collide;
    test_back_to_back_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
